mux2x1_rr_sched: RTL and testbench
==================================

Name: mux2x1_rr_sched

Overview:
- Round-robin scheduler that merges two upstream FIFO queues (port 0, port 1) into one output stream through the 2:1 mux datapath.
- Decides which queue to pop each cycle, applies a burst limit, and honours downstream back-pressure.
- Registers the selected word and tags it with the source selector and valid.
- Sits between the two input FIFOs and the downstream FIFO in the merge path.

Parameters:
- BW, 8, data width of each queue word and of data_out.
- BURST, 4, maximum consecutive grants to one port while the other port is requesting (BURST >= 1).
- CNT_W, 3, burst counter width; must hold BURST-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- empty0  input  1  queue 0 empty flag.
- empty1  input  1  queue 1 empty flag.
- data0  input  BW  head word of queue 0; valid while empty0=0.
- data1  input  BW  head word of queue 1; valid while empty1=0.
- almost_full_out  input  1  downstream back-pressure; 1 = no pops this cycle.
- pop0  output  1  combinational; consumes the queue 0 head at this clock edge.
- pop1  output  1  combinational; consumes the queue 1 head at this clock edge.
- data_out  output  BW  registered merged word.
- valid_out  output  1  registered; data_out holds a new word this cycle.
- selector  output  1  registered source of data_out (0 = queue 0, 1 = queue 1).
- busy  output  1  registered; 1 while the FSM is in SERVE0 or SERVE1.

Behaviour:
- Reset (asynchronous, while reset=1):
  - state=IDLE, cnt=0, last=1 (so port 0 wins the first contention).
  - data_out=0, valid_out=0, selector=0, busy=0.
  - pop0=pop1=0, forced combinationally while reset=1.
- Requests: req_i = ~empty_i & ~almost_full_out.
- States: IDLE, SERVE0, SERVE1. busy = (state != IDLE).
- Grant g (combinational, at most one pop per cycle):
  - No req: no grant.
  - Only req_i: g=i.
  - Both req, state IDLE: g = ~last.
  - Both req, state SERVE_i, cnt < BURST-1: g=i.
  - Both req, state SERVE_i, cnt = BURST-1: g = other port.
- pop_g=1 only when a grant exists; never pop0 and pop1 together; never pop an empty queue.
- On an edge with a grant:
  - state <= SERVE_g, last <= g.
  - cnt <= (state==SERVE_g) ? min(cnt+1, BURST-1) : 0.
  - data_out <= data_g, selector <= g, valid_out <= 1. Latency: one cycle from pop to valid_out.
- On an edge without a grant: valid_out <= 0; data_out and selector hold.
  - almost_full_out=1: state and cnt freeze (a paused burst resumes with its count intact).
  - almost_full_out=0 and both queues empty: state <= IDLE, cnt <= 0.
- Saturation: cnt saturates at BURST-1 while the other port is idle. When the other port then requests, switch on its first requesting cycle.
- BURST=1 gives strict alternation under contention.
- Fairness: under continuous contention, exactly BURST grants per port per turn.
- Back-pressure: almost_full_out asserting combinationally deasserts pops in the same cycle; no word is lost or duplicated.
- Reset asserted mid-burst: everything clears immediately. In-flight data_out is discarded. Arbitration restarts with port 0 priority.

Test Plan:
- Reset, then both queues load 6 words (A0..A5, B0..B5), BURST=4, no back-pressure → output order A0..A3, B0..B3, A4, A5, B4, B5 with selector 0000 1111 0 0 1 1. valid_out continuous, first word one cycle after first pop.
- Only queue 1 holds 3 words → pop1 for 3 cycles, selector=1, then IDLE with busy=0. pop0 never asserts.
- Contention, almost_full_out pulsed high for 2 cycles after the 2nd port-0 grant → no pops or valid_out during the pulse. Then 2 more port-0 words, then switch to port 1 (count preserved).
- Queue 0 alone for 7 words, queue 1 becomes non-empty at word 5 → port 1 granted on the next cycle (cnt saturated), then alternation resumes.
- BURST=1, both queues with 4 words → strict alternation 0,1,0,1,... over 8 cycles.
- reset asserted asynchronously mid-burst (between edges) → outputs return to 0 and pops drop immediately. After release with both queues non-empty, port 0 is granted first.

Source files
------------

// File: rtl/mux2x1_rr_sched.sv
// rtl/mux2x1_rr_sched.sv - two-queue round-robin merge scheduler with burst limit
// Pops at most one input queue per cycle and registers the chosen word with its source tag.
module mux2x1_rr_sched #(
   parameter int BW    = 8,
   parameter int BURST = 4,
   parameter int CNT_W = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          empty0,
   input  logic          empty1,
   input  logic [BW-1:0] data0,
   input  logic [BW-1:0] data1,
   input  logic          almost_full_out,
   output logic          pop0,
   output logic          pop1,
   output logic [BW-1:0] data_out,
   output logic          valid_out,
   output logic          selector,
   output logic          busy
);

   localparam logic [1:0]       IDLE    = 2'd0;
   localparam logic [1:0]       SERVE0  = 2'd1;
   localparam logic [1:0]       SERVE1  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

   logic [1:0]       state;
   logic [1:0]       gnt_state;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             req0;
   logic             req1;
   logic             gnt_vld;
   logic             gnt;

   assign req0 = ~empty0 & ~almost_full_out;
   assign req1 = ~empty1 & ~almost_full_out;

   // Under contention the serving port keeps the grant until its burst count is spent.
   always_comb begin
      gnt_vld = req0 | req1;
      gnt     = req1;
      if (req0 && req1) begin
         case (state)
            SERVE0:  gnt = (cnt == CNT_MAX);
            SERVE1:  gnt = (cnt != CNT_MAX);
            default: gnt = ~last;
         endcase
      end
      gnt_state = gnt ? SERVE1 : SERVE0;
   end

   assign pop0 = gnt_vld & ~gnt & ~reset;
   assign pop1 = gnt_vld &  gnt & ~reset;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         data_out  <= '0;
         valid_out <= 1'b0;
         selector  <= 1'b0;
      end else if (gnt_vld) begin
         state     <= gnt_state;
         last      <= gnt;
         data_out  <= gnt ? data1 : data0;
         selector  <= gnt;
         valid_out <= 1'b1;
         if (state == gnt_state)
            cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
         else
            cnt <= '0;
      end else begin
         valid_out <= 1'b0;
         // Back-pressure freezes state and count so a paused burst resumes where it left off.
         if (!almost_full_out) begin
            state <= IDLE;
            cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mux2x1_rr_sched.sv
// tb/tb_mux2x1_rr_sched.sv - directed self-checking bench for mux2x1_rr_sched
// Two instances: default burst of 4, and burst of 1 for the alternation case.
module tb_mux2x1_rr_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       af = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic       e0, e1, p0, p1, vout, sel, busy;
   logic [7:0] d0, d1, dout;
   logic       ae0, ae1, ap0, ap1, avout, asel, abusy;
   logic [7:0] ad0, ad1, adout;

   logic [7:0] m0 [64];
   logic [7:0] m1 [64];
   logic [7:0] n0 [64];
   logic [7:0] n1 [64];
   int h0 = 0, h1 = 0, t0 = 0, t1 = 0;
   int k0 = 0, k1 = 0, u0 = 0, u1 = 0;

   always #5 clk = ~clk;

   assign e0  = (h0 == t0);
   assign e1  = (h1 == t1);
   assign d0  = m0[h0[5:0]];
   assign d1  = m1[h1[5:0]];
   assign ae0 = (k0 == u0);
   assign ae1 = (k1 == u1);
   assign ad0 = n0[k0[5:0]];
   assign ad1 = n1[k1[5:0]];

   mux2x1_rr_sched #(.BW(8), .BURST(4), .CNT_W(3)) u_dut (
      .clk(clk), .reset(reset), .empty0(e0), .empty1(e1), .data0(d0), .data1(d1),
      .almost_full_out(af), .pop0(p0), .pop1(p1), .data_out(dout),
      .valid_out(vout), .selector(sel), .busy(busy));

   mux2x1_rr_sched #(.BW(8), .BURST(1), .CNT_W(1)) u_alt (
      .clk(clk), .reset(reset), .empty0(ae0), .empty1(ae1), .data0(ad0), .data1(ad1),
      .almost_full_out(af), .pop0(ap0), .pop1(ap1), .data_out(adout),
      .valid_out(avout), .selector(asel), .busy(abusy));

   // Queue models: heads advance on pops; illegal pops are flagged as they happen.
   always @(posedge clk) begin
      if ((p0 && p1) || (p0 && e0) || (p1 && e1) || (ap0 && ap1) || (ap0 && ae0) || (ap1 && ae1)) begin
         bad++;
         $display("FAIL pop_protocol got p0=%b p1=%b e0=%b e1=%b ap0=%b ap1=%b want legal single pop",
                  p0, p1, e0, e1, ap0, ap1);
      end
      if (p0)  h0 <= h0 + 1;
      if (p1)  h1 <= h1 + 1;
      if (ap0) k0 <= k0 + 1;
      if (ap1) k1 <= k1 + 1;
   end

   task automatic push0(input logic [7:0] v); m0[t0[5:0]] = v; t0++; endtask
   task automatic push1(input logic [7:0] v); m1[t1[5:0]] = v; t1++; endtask
   task automatic step; @(posedge clk); #1; endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push0(8'hA0 + 8'(i));
         push1(8'hB0 + 8'(i));
      end
      step; step;
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", dout); end
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vout); end
      total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b want=0", sel); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (p0 !== 1'b0) begin bad++; $display("FAIL rst_pop0 got=%b want=0", p0); end
      total++; if (p1 !== 1'b0) begin bad++; $display("FAIL rst_pop1 got=%b want=0", p1); end
   endtask

   task automatic test_round_robin;
      logic [11:0] src_tbl = 12'b1100_1111_0000;
      logic [7:0]  na = 8'h00, nb = 8'h00, exp;
      logic        s;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 12; i++) begin
         s = src_tbl[i];
         exp = s ? 8'hB0 + nb : 8'hA0 + na;
         total++; if (p0 !== !s) begin bad++; $display("FAIL rr_pop0[%0d] got=%b want=%b", i, p0, !s); end
         total++; if (p1 !== s) begin bad++; $display("FAIL rr_pop1[%0d] got=%b want=%b", i, p1, s); end
         step;
         total++; if (vout !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=1", i, vout); end
         total++; if (dout !== exp) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", i, dout, exp); end
         total++; if (sel !== s) begin bad++; $display("FAIL rr_sel[%0d] got=%b want=%b", i, sel, s); end
         if (s) nb++; else na++;
      end
      total++; if ({p0, p1} !== 2'b00) begin bad++; $display("FAIL rr_end_pops got=%b%b want=00", p0, p1); end
      step;
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL rr_end_valid got=%b want=0", vout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_end_busy got=%b want=0", busy); end
      total++; if (dout !== 8'hB5) begin bad++; $display("FAIL rr_end_hold got=%h want=b5", dout); end
   endtask

   task automatic test_single_queue;
      for (int i = 0; i < 3; i++) push1(8'hC0 + 8'(i));
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if ({p0, p1} !== 2'b01) begin bad++; $display("FAIL sq_pops[%0d] got=%b%b want=01", i, p0, p1); end
         step;
         total++; if (dout !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL sq_data[%0d] got=%h want=%h", i, dout, 8'hC0 + 8'(i)); end
         total++; if ({vout, sel, busy} !== 3'b111) begin bad++; $display("FAIL sq_flags[%0d] got=%b%b%b want=111", i, vout, sel, busy); end
      end
      total++; if ({p0, p1} !== 2'b00) begin bad++; $display("FAIL sq_end_pops got=%b%b want=00", p0, p1); end
      step;
      total++; if ({vout, busy} !== 2'b00) begin bad++; $display("FAIL sq_idle got=%b%b want=00", vout, busy); end
   endtask

   task automatic test_back_pressure;
      logic [11:0] src_tbl = 12'b1100_1111_0000;
      logic [7:0]  na = 8'h00, nb = 8'h00, exp;
      logic        s;
      for (int i = 0; i < 6; i++) begin
         push0(8'hD0 + 8'(i));
         push1(8'hE0 + 8'(i));
      end
      #1;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) begin
            af = 1'b1;
            #1;
            for (int j = 0; j < 2; j++) begin
               total++; if ({p0, p1} !== 2'b00) begin bad++; $display("FAIL bp_pops[%0d] got=%b%b want=00", j, p0, p1); end
               step;
               total++; if (vout !== 1'b0) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=0", j, vout); end
               total++; if (dout !== 8'hD1) begin bad++; $display("FAIL bp_hold[%0d] got=%h want=d1", j, dout); end
               total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%b want=1", j, busy); end
            end
            af = 1'b0;
            #1;
         end
         s = src_tbl[i];
         exp = s ? 8'hE0 + nb : 8'hD0 + na;
         total++; if ({p0, p1} !== {!s, s}) begin bad++; $display("FAIL bp_grant[%0d] got=%b%b want=%b%b", i, p0, p1, !s, s); end
         step;
         total++; if (dout !== exp) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, dout, exp); end
         total++; if ({vout, sel} !== {1'b1, s}) begin bad++; $display("FAIL bp_vs[%0d] got=%b%b want=1%b", i, vout, sel, s); end
         if (s) nb++; else na++;
      end
      step;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", busy); end
   endtask

   task automatic test_saturation;
      logic [8:0] src_tbl = 9'b0_0110_0000;
      logic [7:0] na = 8'h00, nb = 8'h00, exp;
      logic       s;
      for (int i = 0; i < 7; i++) push0(8'hF0 + 8'(i));
      #1;
      for (int i = 0; i < 9; i++) begin
         if (i == 5) begin
            push1(8'h90);
            push1(8'h91);
            #1;
         end
         s = src_tbl[i];
         exp = s ? 8'h90 + nb : 8'hF0 + na;
         total++; if ({p0, p1} !== {!s, s}) begin bad++; $display("FAIL sat_grant[%0d] got=%b%b want=%b%b", i, p0, p1, !s, s); end
         step;
         total++; if (dout !== exp) begin bad++; $display("FAIL sat_data[%0d] got=%h want=%h", i, dout, exp); end
         total++; if ({vout, sel} !== {1'b1, s}) begin bad++; $display("FAIL sat_vs[%0d] got=%b%b want=1%b", i, vout, sel, s); end
         if (s) nb++; else na++;
      end
      step;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_idle got=%b want=0", busy); end
   endtask

   task automatic test_burst_one;
      logic [7:0] exp;
      logic       s;
      for (int i = 0; i < 4; i++) begin
         n0[u0[5:0]] = 8'h10 + 8'(i); u0++;
         n1[u1[5:0]] = 8'h20 + 8'(i); u1++;
      end
      #1;
      for (int i = 0; i < 8; i++) begin
         s = i[0];
         exp = (s ? 8'h20 : 8'h10) + 8'(i / 2);
         total++; if ({ap0, ap1} !== {!s, s}) begin bad++; $display("FAIL b1_grant[%0d] got=%b%b want=%b%b", i, ap0, ap1, !s, s); end
         step;
         total++; if (adout !== exp) begin bad++; $display("FAIL b1_data[%0d] got=%h want=%h", i, adout, exp); end
         total++; if ({avout, asel} !== {1'b1, s}) begin bad++; $display("FAIL b1_vs[%0d] got=%b%b want=1%b", i, avout, asel, s); end
      end
      step;
      total++; if ({avout, abusy} !== 2'b00) begin bad++; $display("FAIL b1_idle got=%b%b want=00", avout, abusy); end
   endtask

   task automatic test_reset_mid_burst;
      int cyc;
      for (int i = 0; i < 6; i++) begin
         push0(8'h30 + 8'(i));
         push1(8'h40 + 8'(i));
      end
      #1;
      // Last grant before this was port 0, so port 1 wins the idle contention.
      for (int i = 0; i < 2; i++) begin
         total++; if ({p0, p1} !== 2'b01) begin bad++; $display("FAIL mr_grant[%0d] got=%b%b want=01", i, p0, p1); end
         step;
         total++; if (dout !== 8'h40 + 8'(i)) begin bad++; $display("FAIL mr_data[%0d] got=%h want=%h", i, dout, 8'h40 + 8'(i)); end
      end
      #3;
      reset = 1'b1;
      #1;
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL mr_rst_data got=%h want=00", dout); end
      total++; if ({vout, sel, busy} !== 3'b000) begin bad++; $display("FAIL mr_rst_flags got=%b%b%b want=000", vout, sel, busy); end
      total++; if ({p0, p1} !== 2'b00) begin bad++; $display("FAIL mr_rst_pops got=%b%b want=00", p0, p1); end
      step;
      reset = 1'b0;
      #1;
      total++; if ({p0, p1} !== 2'b10) begin bad++; $display("FAIL mr_first got=%b%b want=10", p0, p1); end
      step;
      total++; if (dout !== 8'h30) begin bad++; $display("FAIL mr_first_data got=%h want=30", dout); end
      total++; if ({vout, sel} !== 2'b10) begin bad++; $display("FAIL mr_first_vs got=%b%b want=10", vout, sel); end
      cyc = 0;
      while ((!e0 || !e1 || busy) && cyc < 40) begin
         step;
         cyc++;
      end
      total++; if (cyc >= 40) begin bad++; $display("FAIL mr_drain got=timeout want=idle within 40 cycles"); end
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_single_queue;
      test_back_pressure;
      test_saturation;
      test_burst_one;
      test_reset_mid_burst;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
